// File: rtl/uart_cmd_fsm_v2.sv
// Host command interpreter between the UART RX/TX blocks and the ADC, trigger
// and FIFO control logic.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   tx_data/tx_valid  byte to transmit, held until tx_ready
//   tx_ready          transmitter accepts tx_data on tx_valid && tx_ready
//   status_in         NUM_STATUS packed 4-bit status channels
//   cmd_pulse         one-hot command strobes (bit 13 is the DCM reset pulse)
//   arg_data          last completed argument, first received bit in the MSB
//   arg_valid         strobe when arg_data updates
//   arg_abort         strobe when argument collection fails
//   echo_en           echo mode flag
//   echo_drop         sticky flag, an echo byte was lost (cleared by 'R')
module uart_cmd_fsm_v2 #(
  parameter int unsigned ARG_BITS      = 10,
  parameter int unsigned NUM_STATUS    = 4,
  parameter int unsigned TIMEOUT_CYC   = 1000000,
  parameter int unsigned RST_PULSE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  input  logic [4*NUM_STATUS-1:0] status_in,
  output logic [13:0]             cmd_pulse,
  output logic [ARG_BITS-1:0]     arg_data,
  output logic                    arg_valid,
  output logic                    arg_abort,
  output logic                    echo_en,
  output logic                    echo_drop
);

  localparam int unsigned CW = $clog2(ARG_BITS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned PW = $clog2(RST_PULSE_CYC + 1);

  localparam logic [7:0] ChOk  = 8'h2A;  // '*'
  localparam logic [7:0] ChErr = 8'h21;  // '!'

  typedef enum logic [2:0] {StIdle, StArg, StQuery, StResp, StDcm} state_e;

  state_e              state_q, state_d;
  logic [7:0]          resp_q, resp_d;
  logic                resp_sent_q, resp_sent_d;
  logic [ARG_BITS-1:0] arg_sr_q, arg_sr_d;
  logic [CW-1:0]       arg_cnt_q, arg_cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [PW-1:0]       dcm_cnt_q, dcm_cnt_d;
  logic [ARG_BITS-1:0] arg_data_q, arg_data_d;
  logic                arg_valid_q, arg_valid_d;
  logic                arg_abort_q, arg_abort_d;
  logic [13:0]         cmd_pulse_q, cmd_pulse_d;
  logic                echo_en_q, echo_en_d;
  logic                echo_drop_q, echo_drop_d;
  logic                echo_full_q, echo_full_d;
  logic [7:0]          echo_byte_q, echo_byte_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                tx_is_echo_q, tx_is_echo_d;
  logic                tx_is_resp_q, tx_is_resp_d;

  logic [13:0]         cmd_hot;
  logic [3:0]          q_nib;
  logic                q_ok;
  logic                is_r;
  logic                timeout;
  logic                tx_free;
  logic                echo_occ;
  logic [ARG_BITS-1:0] arg_sr_next;

  // Single-character command decode (excludes 'r', which goes through StDcm).
  always_comb begin
    cmd_hot = '0;
    case (rx_data)
      8'h4F: cmd_hot[0]  = 1'b1;  // 'O'
      8'h6F: cmd_hot[1]  = 1'b1;  // 'o'
      8'h53: cmd_hot[2]  = 1'b1;  // 'S'
      8'h57: cmd_hot[3]  = 1'b1;  // 'W'
      8'h43: cmd_hot[4]  = 1'b1;  // 'C'
      8'h44: cmd_hot[5]  = 1'b1;  // 'D'
      8'h64: cmd_hot[6]  = 1'b1;  // 'd'
      8'h54: cmd_hot[7]  = 1'b1;  // 'T'
      8'h74: cmd_hot[8]  = 1'b1;  // 't'
      8'h55: cmd_hot[9]  = 1'b1;  // 'U'
      8'h58: cmd_hot[10] = 1'b1;  // 'X'
      8'h42: cmd_hot[11] = 1'b1;  // 'B'
      8'h62: cmd_hot[12] = 1'b1;  // 'b'
      default: cmd_hot = '0;
    endcase
  end

  // Status channel select from an ASCII digit.
  always_comb begin
    q_nib = '0;
    q_ok  = 1'b0;
    for (int k = 0; k < int'(NUM_STATUS); k++) begin
      if (rx_data == 8'(8'h30 + k)) begin
        q_ok  = 1'b1;
        q_nib = status_in[4*k +: 4];
      end
    end
  end

  assign is_r        = rx_valid && (rx_data == 8'h52);
  assign timeout     = (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign arg_sr_next = (arg_sr_q << 1) | ARG_BITS'(rx_data[0]);
  assign tx_free     = !tx_valid_q || tx_ready;
  // An echo byte occupies the slot until the transmitter has accepted it.
  assign echo_occ    = echo_full_q || (tx_valid_q && tx_is_echo_q && !tx_ready);

  always_comb begin
    state_d      = state_q;
    resp_d       = resp_q;
    resp_sent_d  = resp_sent_q;
    arg_sr_d     = arg_sr_q;
    arg_cnt_d    = arg_cnt_q;
    tmr_d        = '0;
    dcm_cnt_d    = dcm_cnt_q;
    arg_data_d   = arg_data_q;
    arg_valid_d  = 1'b0;
    arg_abort_d  = 1'b0;
    cmd_pulse_d  = '0;
    echo_en_d    = echo_en_q;
    echo_drop_d  = echo_drop_q;
    echo_full_d  = echo_full_q;
    echo_byte_d  = echo_byte_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    tx_is_echo_d = tx_is_echo_q;
    tx_is_resp_d = tx_is_resp_q;

    unique case (state_q)
      StIdle: begin
        if (rx_valid) begin
          if (cmd_hot != '0) begin
            cmd_pulse_d = cmd_hot;
            state_d     = StResp;
            resp_d      = ChOk;
          end else begin
            state_d = StResp;
            resp_d  = ChOk;
            case (rx_data)
              8'h72: begin  // 'r'
                cmd_pulse_d[13] = 1'b1;
                dcm_cnt_d       = PW'(1);
                state_d         = StDcm;
              end
              8'h45: echo_en_d = 1'b1;  // 'E'
              8'h65: echo_en_d = 1'b0;  // 'e'
              8'h56: begin  // 'V'
                state_d   = StArg;
                arg_cnt_d = '0;
                arg_sr_d  = '0;
              end
              8'h51: state_d = StQuery;  // 'Q'
              default: resp_d = ChErr;
            endcase
          end
        end
      end

      StArg: begin
        if (rx_valid) begin
          if (rx_data == 8'h30 || rx_data == 8'h31) begin
            arg_sr_d = arg_sr_next;
            if (arg_cnt_q == CW'(ARG_BITS - 1)) begin
              arg_data_d  = arg_sr_next;
              arg_valid_d = 1'b1;
              arg_cnt_d   = '0;
              state_d     = StResp;
              resp_d      = ChOk;
            end else begin
              arg_cnt_d = arg_cnt_q + CW'(1);
            end
          end else begin
            arg_abort_d = 1'b1;
            state_d     = StResp;
            resp_d      = ChErr;
          end
        end else if (timeout) begin
          arg_abort_d = 1'b1;
          state_d     = StResp;
          resp_d      = ChErr;
        end else begin
          tmr_d = (tmr_q == TW'(TIMEOUT_CYC)) ? tmr_q : tmr_q + TW'(1);
        end
      end

      StQuery: begin
        if (rx_valid) begin
          state_d = StResp;
          if (q_ok) begin
            resp_d = (q_nib < 4'd10) ? (8'h30 + {4'h0, q_nib}) : (8'h37 + {4'h0, q_nib});
          end else begin
            resp_d = ChErr;
          end
        end else if (timeout) begin
          state_d = StResp;
          resp_d  = ChErr;
        end else begin
          tmr_d = (tmr_q == TW'(TIMEOUT_CYC)) ? tmr_q : tmr_q + TW'(1);
        end
      end

      StDcm: begin
        if (dcm_cnt_q >= PW'(RST_PULSE_CYC)) begin
          dcm_cnt_d = '0;
          state_d   = StResp;
          resp_d    = ChOk;
        end else begin
          cmd_pulse_d[13] = 1'b1;
          dcm_cnt_d       = dcm_cnt_q + PW'(1);
        end
      end

      StResp: begin
        if (resp_sent_q && tx_valid_q && tx_ready && tx_is_resp_q) begin
          state_d     = StIdle;
          resp_sent_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase

    // TX arbiter: a completed handshake frees the register for a new byte
    // in the same edge; the echo slot wins over the pending response.
    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (tx_free) begin
      if (echo_full_q) begin
        tx_data_d    = echo_byte_q;
        tx_valid_d   = 1'b1;
        tx_is_echo_d = 1'b1;
        tx_is_resp_d = 1'b0;
        echo_full_d  = 1'b0;
      end else if (state_q == StResp && !resp_sent_q && !is_r) begin
        tx_data_d    = resp_q;
        tx_valid_d   = 1'b1;
        tx_is_echo_d = 1'b0;
        tx_is_resp_d = 1'b1;
        resp_sent_d  = 1'b1;
      end
    end

    if (echo_en_q && rx_valid) begin
      if (echo_occ) begin
        echo_drop_d = 1'b1;
      end else begin
        echo_full_d = 1'b1;
        echo_byte_d = rx_data;
      end
    end

    // 'R' aborts everything in flight except bytes already on the TX port.
    if (is_r) begin
      state_d     = StIdle;
      arg_sr_d    = '0;
      arg_cnt_d   = '0;
      tmr_d       = '0;
      dcm_cnt_d   = '0;
      resp_sent_d = 1'b0;
      echo_drop_d = 1'b0;
      cmd_pulse_d = '0;
      arg_valid_d = 1'b0;
      arg_abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      resp_q       <= 8'h00;
      resp_sent_q  <= 1'b0;
      arg_sr_q     <= '0;
      arg_cnt_q    <= '0;
      tmr_q        <= '0;
      dcm_cnt_q    <= '0;
      arg_data_q   <= '0;
      arg_valid_q  <= 1'b0;
      arg_abort_q  <= 1'b0;
      cmd_pulse_q  <= '0;
      echo_en_q    <= 1'b0;
      echo_drop_q  <= 1'b0;
      echo_full_q  <= 1'b0;
      echo_byte_q  <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tx_is_echo_q <= 1'b0;
      tx_is_resp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_q       <= resp_d;
      resp_sent_q  <= resp_sent_d;
      arg_sr_q     <= arg_sr_d;
      arg_cnt_q    <= arg_cnt_d;
      tmr_q        <= tmr_d;
      dcm_cnt_q    <= dcm_cnt_d;
      arg_data_q   <= arg_data_d;
      arg_valid_q  <= arg_valid_d;
      arg_abort_q  <= arg_abort_d;
      cmd_pulse_q  <= cmd_pulse_d;
      echo_en_q    <= echo_en_d;
      echo_drop_q  <= echo_drop_d;
      echo_full_q  <= echo_full_d;
      echo_byte_q  <= echo_byte_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_is_echo_q <= tx_is_echo_d;
      tx_is_resp_q <= tx_is_resp_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign cmd_pulse = cmd_pulse_q;
  assign arg_data  = arg_data_q;
  assign arg_valid = arg_valid_q;
  assign arg_abort = arg_abort_q;
  assign echo_en   = echo_en_q;
  assign echo_drop = echo_drop_q;

endmodule

// File: tb/tb_uart_cmd_fsm_v2.sv
// Directed self-checking bench for uart_cmd_fsm_v2 (ARG_BITS=10, NUM_STATUS=4,
// TIMEOUT_CYC=50, RST_PULSE_CYC=2). Inputs change and outputs are sampled on
// the falling clock edge.
module tb_uart_cmd_fsm_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [15:0] status_in = 16'h0000;
  logic [13:0] cmd_pulse;
  logic [9:0]  arg_data;
  logic        arg_valid;
  logic        arg_abort;
  logic        echo_en;
  logic        echo_drop;

  int checks = 0;
  int errors = 0;

  uart_cmd_fsm_v2 #(
    .ARG_BITS     (10),
    .NUM_STATUS   (4),
    .TIMEOUT_CYC  (50),
    .RST_PULSE_CYC(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .status_in(status_in),
    .cmd_pulse(cmd_pulse),
    .arg_data (arg_data),
    .arg_valid(arg_valid),
    .arg_abort(arg_abort),
    .echo_en  (echo_en),
    .echo_drop(echo_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one byte for exactly one clock; returns on the falling edge
  // right after the byte was sampled.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx: got valid=%b data=%h, want 0/00", tx_valid, tx_data);
    end
    checks++;
    if (cmd_pulse !== 14'h0 || arg_valid !== 1'b0 || arg_abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got cmd=%h av=%b ab=%b, want 0", cmd_pulse, arg_valid,
               arg_abort);
    end
    checks++;
    if (arg_data !== 10'h0 || echo_en !== 1'b0 || echo_drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got arg=%h en=%b drop=%b, want 0", arg_data, echo_en,
               echo_drop);
    end
    do_reset();
  endtask

  task automatic test_commands();
    logic [7:0]  bytes [5] = '{8'h4F, 8'h6F, 8'h57, 8'h62, 8'h5A};
    logic [13:0] pulses[5] = '{14'h0001, 14'h0002, 14'h0008, 14'h1000, 14'h0000};
    logic [7:0]  resps [5] = '{8'h2A, 8'h2A, 8'h2A, 8'h2A, 8'h21};
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(bytes[i]);
      checks++;
      if (cmd_pulse !== pulses[i] || tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmd_pulse[%0d]: got cmd=%h txv=%b, want %h/0", i, cmd_pulse, tx_valid,
                 pulses[i]);
      end
      @(negedge clk);
      checks++;
      if (cmd_pulse !== 14'h0 || tx_valid !== 1'b1 || tx_data !== resps[i]) begin
        errors++;
        $display("FAIL cmd_resp[%0d]: got cmd=%h txv=%b d=%h, want 0/1/%h", i, cmd_pulse,
                 tx_valid, tx_data, resps[i]);
      end
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmd_done[%0d]: got txv=%b, want 0", i, tx_valid);
      end
    end
  endtask

  task automatic test_arg();
    logic [9:0] pat = 10'b1011001110;
    tx_ready = 1'b1;
    send(8'h56);
    for (int i = 9; i >= 0; i--) begin
      send(pat[i] ? 8'h31 : 8'h30);
      if (i == 1) begin
        checks++;
        if (arg_valid !== 1'b0) begin
          errors++;
          $display("FAIL arg_early: got arg_valid=%b after 9 bits, want 0", arg_valid);
        end
      end
    end
    checks++;
    if (arg_valid !== 1'b1 || arg_data !== pat) begin
      errors++;
      $display("FAIL arg_done: got av=%b data=%b, want 1/%b", arg_valid, arg_data, pat);
    end
    @(negedge clk);
    checks++;
    if (arg_valid !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h2A) begin
      errors++;
      $display("FAIL arg_resp: got av=%b txv=%b d=%h, want 0/1/2a", arg_valid, tx_valid, tx_data);
    end
    @(negedge clk);
    send(8'h56);
    send(8'h31);
    send(8'h30);
    send(8'h78);
    checks++;
    if (arg_abort !== 1'b1 || arg_data !== pat) begin
      errors++;
      $display("FAIL arg_abort: got ab=%b data=%b, want 1/%b", arg_abort, arg_data, pat);
    end
    @(negedge clk);
    checks++;
    if (arg_abort !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h21) begin
      errors++;
      $display("FAIL abort_resp: got ab=%b txv=%b d=%h, want 0/1/21", arg_abort, tx_valid,
               tx_data);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int abort_at = -1;
    int tx_at    = -1;
    logic [7:0] tx_seen = 8'h00;
    tx_ready = 1'b1;
    send(8'h56);
    send(8'h31);
    send(8'h30);
    send(8'h31);
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (arg_abort === 1'b1 && abort_at < 0) abort_at = j;
      if (tx_valid === 1'b1 && tx_at < 0) begin
        tx_at   = j;
        tx_seen = tx_data;
      end
    end
    checks++;
    if (abort_at != 50) begin
      errors++;
      $display("FAIL timeout_abort: got abort at cycle %0d, want 50", abort_at);
    end
    checks++;
    if (tx_at != 51 || tx_seen !== 8'h21) begin
      errors++;
      $display("FAIL timeout_resp: got tx at %0d data %h, want 51/21", tx_at, tx_seen);
    end
  endtask

  task automatic test_query();
    logic [7:0] digs[4] = '{8'h32, 8'h33, 8'h37, 8'h30};
    logic [7:0] exps[4] = '{8'h33, 8'h43, 8'h21, 8'h35};
    status_in = 16'hC3A5;
    tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(8'h51);
      send(digs[i]);
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exps[i]) begin
        errors++;
        $display("FAIL query[%0d]: got txv=%b d=%h, want 1/%h", i, tx_valid, tx_data, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_echo();
    bit stable = 1'b1;
    tx_ready = 1'b1;
    send(8'h45);
    @(negedge clk);
    checks++;
    if (echo_en !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h2A) begin
      errors++;
      $display("FAIL echo_on: got en=%b txv=%b d=%h, want 1/1/2a (no 'E' echo)", echo_en,
               tx_valid, tx_data);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    send(8'h54);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h54) begin
      errors++;
      $display("FAIL echo_first: got txv=%b d=%h, want 1/54", tx_valid, tx_data);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == 3) begin
        rx_data  = 8'h78;
        rx_valid = 1'b1;
      end
      if (tx_valid !== 1'b1 || tx_data !== 8'h54) stable = 1'b0;
    end
    rx_valid = 1'b0;
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL echo_hold: got tx changed while stalled, want 'T' held");
    end
    checks++;
    if (echo_drop !== 1'b1) begin
      errors++;
      $display("FAIL echo_drop: got %b, want 1", echo_drop);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A) begin
      errors++;
      $display("FAIL echo_then_resp: got txv=%b d=%h, want 1/2a", tx_valid, tx_data);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL echo_drain: got txv=%b, want 0", tx_valid);
    end
    send(8'h52);
    checks++;
    if (echo_drop !== 1'b0) begin
      errors++;
      $display("FAIL r_clears_drop: got %b, want 0", echo_drop);
    end
    repeat (3) @(negedge clk);
    do_reset();
  endtask

  task automatic test_r_dcm();
    bit quiet = 1'b1;
    bit got   = 1'b0;
    tx_ready = 1'b1;
    send(8'h56);
    send(8'h31);
    send(8'h30);
    send(8'h52);
    for (int i = 0; i < 6; i++) begin
      if (tx_valid !== 1'b0 || arg_abort !== 1'b0 || cmd_pulse !== 14'h0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL r_quiet: got activity after 'R', want none");
    end
    send(8'h72);
    checks++;
    if (cmd_pulse !== 14'h2000) begin
      errors++;
      $display("FAIL dcm_c1: got %h, want 2000", cmd_pulse);
    end
    @(negedge clk);
    checks++;
    if (cmd_pulse !== 14'h2000) begin
      errors++;
      $display("FAIL dcm_c2: got %h, want 2000", cmd_pulse);
    end
    @(negedge clk);
    checks++;
    if (cmd_pulse !== 14'h0000) begin
      errors++;
      $display("FAIL dcm_c3: got %h, want 0", cmd_pulse);
    end
    for (int i = 0; i < 5 && !got; i++) begin
      if (tx_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (tx_data !== 8'h2A) begin
          errors++;
          $display("FAIL dcm_resp: got %h, want 2a", tx_data);
        end
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL dcm_resp_timeout: got no tx within 5 cycles, want '*'");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b1;
    send(8'h53);
    @(negedge clk);
    // 'U' is sampled on the edge that completes the response handshake,
    // while still in RESP, so it must be ignored.
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    checks++;
    if (cmd_pulse !== 14'h0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ignore: got cmd=%h txv=%b, want 0/0", cmd_pulse, tx_valid);
    end
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_resp: got txv=%b, want 0", tx_valid);
    end
    send(8'h44);
    checks++;
    if (cmd_pulse !== 14'h0020) begin
      errors++;
      $display("FAIL b2b_next: got %h, want 0020", cmd_pulse);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    tx_ready = 1'b0;
    send(8'h4F);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got txv=%b d=%h, want 0/00", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_commands();
    test_arg();
    test_timeout();
    test_query();
    test_echo();
    test_r_dcm();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_fsm_v2.md
Name: uart_cmd_fsm_v2

Overview: Second-generation host command interpreter that sits between the UART receive/transmit blocks and the ADC, trigger and FIFO control logic. It decodes single-character commands into control pulses and collects a parametrised-width binary argument with an inactivity timeout. It answers status queries for a parametrised number of 4-bit status channels. All transmit traffic uses a valid/ready handshake with echo/response arbitration, so no byte is silently overwritten.

Parameters:
ARG_BITS, 10, number of '0'/'1' characters collected after 'V' (1..32)
NUM_STATUS, 4, number of 4-bit status channels readable with 'Q' (1..10)
TIMEOUT_CYC, 1000000, idle clocks allowed between argument/query characters before error (>=2)
RST_PULSE_CYC, 2, width in clocks of the DCM reset pulse (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until tx_ready
tx_ready  in  1  UART transmitter accepts tx_data when tx_valid&&tx_ready
status_in  in  4*NUM_STATUS  channel k on bits [4k+3:4k]
cmd_pulse  out  14  one-hot command strobes: 0 'O',1 'o',2 'S',3 'W',4 'C',5 'D',6 'd',7 'T',8 't',9 'U',10 'X',11 'B',12 'b',13 'r'
arg_data  out  ARG_BITS  last completed argument, MSB received first
arg_valid  out  1  one-cycle strobe when arg_data updates
arg_abort  out  1  one-cycle strobe when argument collection fails
echo_en  out  1  echo mode flag
echo_drop  out  1  sticky: an echo byte was lost; cleared by 'R'

Behaviour:
- Reset: state IDLE; all outputs 0; tx_data 8'h00; arg_data 0; internal counters 0.
- States: IDLE, ARG, QUERY, RESP, DCM.
- 'R' received in any state -> IDLE next cycle. Clears the argument shift register, counters, pending response and echo_drop. It does not clear an echo byte already presented, and produces no response.
- IDLE, rx_valid:
  - Mapped command: cmd_pulse bit high for exactly the next cycle, then RESP with '*'.
  - 'r': DCM, bit 13 high RST_PULSE_CYC cycles, then RESP with '*'.
  - 'E'/'e': set/clear echo_en, then RESP '*'.
  - 'V': ARG, bit counter 0.
  - 'Q': QUERY.
  - Any other byte: RESP with '!'.
- ARG, rx_valid:
  - '0'/'1' shifts into the register LSB; counter +1.
  - When counter reaches ARG_BITS: arg_data updates, arg_valid pulses, then RESP '*'.
  - Any other character: arg_abort pulses, arg_data unchanged, RESP '!'.
- QUERY, rx_valid:
  - Digit '0'..('0'+NUM_STATUS-1): RESP with the ASCII hex of that nibble ('0'-'9','A'-'F').
  - Otherwise: RESP '!'.
- Timeout: in ARG/QUERY, cycles since the last accepted byte (or state entry) reaching TIMEOUT_CYC -> RESP '!'. In ARG this also pulses arg_abort.
- RESP: response byte is pending. Return to IDLE in the cycle the response handshake completes. rx bytes other than 'R' in RESP/DCM are ignored (not decoded), but are still echoed.
- Echo: when echo_en and rx_valid, the byte is captured into a one-entry echo slot.
  - If the slot is still occupied at that moment, the new byte is dropped and echo_drop set.
  - The echo byte of the command that turns echo on ('E') is not echoed. The byte of 'e' is echoed.
- TX arbiter:
  - Echo slot has priority over a pending response.
  - tx_data/tx_valid are registered and stable while tx_valid&&!tx_ready.
  - After a handshake, the next byte may be presented the following cycle.
  - Minimum latency command->'*' on tx_valid: 2 cycles with tx_ready=1 and no echo.
- Simultaneous: timeout and rx_valid in the same cycle -> the byte wins, timeout discarded.
- Widths: arg register ARG_BITS; bit counter ceil(log2(ARG_BITS+1)); timeout counter ceil(log2(TIMEOUT_CYC+1)), saturating.
- Async reset mid-transfer drops tx_valid immediately; the partial argument is discarded.

Test Plan:
- rst_n low, then 'O' with tx_ready=1 -> cmd_pulse[0] one cycle; tx_data '*' tx_valid two cycles after rx_valid; state returns to IDLE.
- 'V' then "1011001110", ARG_BITS=10 -> arg_data=10'b1011001110, arg_valid one cycle, then '*'. Repeat with "10x" -> arg_abort, arg_data unchanged, '!'.
- 'V', "101", then silence with TIMEOUT_CYC=50 -> arg_abort and '!' exactly 50 cycles after the last '1'.
- status_in=16'hC3A5, 'Q' then '2' -> tx '3'; 'Q' then '3' -> 'C'; 'Q' then '7' with NUM_STATUS=4 -> '!'.
- 'E' then 'T' with tx_ready held low 20 cycles -> tx_data 'E' not sent, 'T' held stable until ready, then '*'. A second echo byte arriving while 'T' is held sets echo_drop.
- 'V', "10", then 'R' -> IDLE, no response. Next 'r' with RST_PULSE_CYC=2 -> cmd_pulse[13] high exactly 2 cycles, then '*'.
